// File: rtl/phi2_stretch_controller.sv
// PHI2 generator: nominal HALF-cycle low/high phases, with the high phase stretched per latched address region.
// Optional EXT_WAIT_EN adds an EXT_WAIT input that holds PHI2 high for as long as it is asserted.
module phi2_stretch_controller #(
    parameter int unsigned HALF     = 2,
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] ADDR,
    input  logic       RWB,
`ifdef EXT_WAIT_EN
    input  logic       EXT_WAIT,
`endif
    output logic       PHI2,
    output logic [1:0] REGION,
    output logic       RWB_Q,
    output logic       STRETCHING,
    output logic       CYCLE_END
);

    localparam logic [3:0] HALF_M1 = 4'(HALF - 1);
    localparam logic [3:0] ROM_W   = 4'(ROM_WAIT);
    localparam logic [3:0] IO_W    = 4'(IO_WAIT);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_HIGH    = 2'd1,
        ST_STRETCH = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] wait_q, wait_d;
    logic [1:0] region_q, region_d;
    logic       rwb_lat_q, rwb_lat_d;
    logic       phi2_q, phi2_d;
    logic       stretching_q, stretching_d;
    logic       cycle_end_q, cycle_end_d;
    logic [1:0] addr_region;
    logic       ext_wait;

`ifdef EXT_WAIT_EN
    assign ext_wait = EXT_WAIT;
`else
    assign ext_wait = 1'b0;
`endif

    // Same memory map as the address decoder: ROM 0xE000-0xFFFF, ACIA 0x8000-0x83FF.
    function automatic logic [1:0] decode_region(input logic [5:0] a);
        if (a[5:3] == 3'b111)
            return 2'd1;
        else if (a == 6'b100000)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    function automatic logic [3:0] region_wait(input logic [1:0] r);
        case (r)
            2'd1:    return ROM_W;
            2'd2:    return IO_W;
            default: return 4'd0;
        endcase
    endfunction

    assign addr_region = decode_region(ADDR);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        region_d     = region_q;
        rwb_lat_d    = rwb_lat_q;
        phi2_d       = phi2_q;
        stretching_d = 1'b0;
        cycle_end_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (cnt_q == 4'd0) begin
                    region_d  = addr_region;
                    rwb_lat_d = RWB;
                    wait_d    = region_wait(addr_region);
                    state_d   = ST_HIGH;
                    cnt_d     = HALF_M1;
                    phi2_d    = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    phi2_d = 1'b0;
                end
            end
            ST_HIGH: begin
                phi2_d = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (wait_q != 4'd0 || ext_wait) begin
                    state_d      = ST_STRETCH;
                    cnt_d        = (wait_q != 4'd0) ? wait_q - 4'd1 : 4'd0;
                    stretching_d = 1'b1;
                end else begin
                    state_d     = ST_LOW;
                    cnt_d       = HALF_M1;
                    phi2_d      = 1'b0;
                    cycle_end_d = 1'b1;
                end
            end
            ST_STRETCH: begin
                phi2_d       = 1'b1;
                stretching_d = 1'b1;
                // Counter saturates at zero while an external hold keeps the stretch going.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!ext_wait) begin
                    state_d      = ST_LOW;
                    cnt_d        = HALF_M1;
                    phi2_d       = 1'b0;
                    stretching_d = 1'b0;
                    cycle_end_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = HALF_M1;
                phi2_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_LOW;
            cnt_q        <= HALF_M1;
            wait_q       <= 4'd0;
            region_q     <= 2'd0;
            rwb_lat_q    <= 1'b1;
            phi2_q       <= 1'b0;
            stretching_q <= 1'b0;
            cycle_end_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            region_q     <= region_d;
            rwb_lat_q    <= rwb_lat_d;
            phi2_q       <= phi2_d;
            stretching_q <= stretching_d;
            cycle_end_q  <= cycle_end_d;
        end
    end

    assign PHI2       = phi2_q;
    assign REGION     = region_q;
    assign RWB_Q      = rwb_lat_q;
    assign STRETCHING = stretching_q;
    assign CYCLE_END  = cycle_end_q;

endmodule
